// File: rtl/coef_mult_pipe.sv
// Constant-coefficient multiplier built from shift-add terms, two-stage pipeline with
// optional group accumulation, saturating or wrapping range reduction and valid/ready flow.
module coef_mult_pipe #(
    parameter int DATA_W = 25,
    parameter int OUT_W  = 25,
    parameter int SAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [3:0]        coef_sel,
    input  logic              coef_neg,
    input  logic              acc_mode,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_ovf
);

    localparam int PW = DATA_W + 6;   // full-precision product width
    localparam int SW = OUT_W + 7;    // accumulate-sum width, never overflows internally

    // Stage 1 registers
    logic          s1_valid;
    logic [PW-1:0] s1_t0, s1_t1, s1_t2;
    logic          s1_sub, s1_neg, s1_acc, s1_last;

    // Stage 2 / output registers
    logic             out_valid_q, out_ovf_q, acc_ovf;
    logic [OUT_W-1:0] out_data_q, acc_q;

    logic s1_adv, s2_adv;
    assign s2_adv = ~out_valid_q | out_ready;
    assign s1_adv = ~s1_valid | s2_adv;

    assign in_ready  = ~rst & s1_adv;
    assign out_valid = ~rst & out_valid_q;
    assign out_data  = rst ? '0 : out_data_q;
    assign out_ovf   = ~rst & out_ovf_q;

    // Coefficient decomposition: product = t0 + t1 +/- t2
    logic [PW-1:0] xe, t0, t1, t2;
    logic          sub;
    assign xe = {{6{in_data[DATA_W-1]}}, in_data};

    always_comb begin
        // NOTE: combinational logic uses blocking '=' and defaults every output first, so no latch is inferred.
        t0  = '0;
        t1  = '0;
        t2  = '0;
        sub = 1'b0;
        case (coef_sel)
            4'd0:  begin t0 = xe << 5; t1 = xe << 3; t2 = xe;      sub = 1'b1; end  // 39 = 32+8-1
            4'd1:  begin t0 = xe << 5; t1 = xe << 2;                           end  // 36
            4'd2:  begin t0 = xe << 5; t1 = xe << 1; t2 = xe;                  end  // 35
            4'd3:  begin t0 = xe << 5; t2 = xe << 1;               sub = 1'b1; end  // 30
            4'd4:  begin t0 = xe << 4; t1 = xe << 1; t2 = xe;                  end  // 19
            4'd5:  begin t0 = xe << 4;                                         end  // 16
            4'd6:  begin t0 = xe << 4; t2 = xe;                    sub = 1'b1; end  // 15
            4'd7:  begin t0 = xe << 4; t2 = xe << 1;               sub = 1'b1; end  // 14
            4'd8:  begin t0 = xe << 3;                                         end  // 8
            4'd9:  begin t0 = xe << 2; t1 = xe << 1;                           end  // 6
            4'd10: begin t0 = xe << 1;                                         end  // 2
            4'd11: begin t0 = xe;                                              end  // 1
            default: ;
        endcase
    end

    // Stage 2 arithmetic
    logic signed [PW-1:0]    prod, sprod;
    logic signed [OUT_W-1:0] acc_base;
    logic signed [SW-1:0]    sum;
    logic [SW-OUT_W:0]       hi;
    logic                    fits, produce, ovf_total;
    logic [OUT_W-1:0]        reduced;

    always_comb begin
        prod      = s1_sub ? $signed(s1_t0 + s1_t1 - s1_t2) : $signed(s1_t0 + s1_t1 + s1_t2);
        sprod     = s1_neg ? -prod : prod;
        acc_base  = s1_acc ? $signed(acc_q) : '0;
        sum       = SW'(acc_base) + SW'(sprod);
        hi        = sum[SW-1:OUT_W-1];
        fits      = (&hi) | (~|hi);
        reduced   = sum[OUT_W-1:0];
        if (!fits && SAT != 0)
            reduced = sum[SW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        ovf_total = ~fits | (s1_acc & acc_ovf);
        produce   = ~s1_acc | s1_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            acc_q       <= '0;
            acc_ovf     <= 1'b0;
        end else begin
            if (s1_adv)
                s1_valid <= in_valid;
            if (s2_adv) begin
                if (s1_valid && produce) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= reduced;
                    out_ovf_q   <= ovf_total;
                    acc_q       <= '0;
                    acc_ovf     <= 1'b0;
                end else begin
                    out_valid_q <= 1'b0;
                    if (s1_valid) begin
                        acc_q   <= reduced;
                        acc_ovf <= ovf_total;
                    end
                end
            end
        end
    end

    // NOTE: stage-1 payload needs no reset; s1_valid alone says whether it means anything.
    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            s1_t0   <= t0;
            s1_t1   <= t1;
            s1_t2   <= t2;
            s1_sub  <= sub;
            s1_neg  <= coef_neg;
            s1_acc  <= acc_mode;
            s1_last <= in_last;
        end
    end

endmodule

// File: tb/tb_coef_mult_pipe.sv
// Directed bench for coef_mult_pipe: one saturating and one wrapping instance share the stimulus.
module tb_coef_mult_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [24:0] in_data = '0;
    logic [3:0]  coef_sel = '0;
    logic        coef_neg = 1'b0, acc_mode = 1'b0, in_last = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready1, out_valid1, out_ovf1;
    logic [24:0] out_data1;
    logic        in_ready0, out_valid0, out_ovf0;
    logic [24:0] out_data0;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [24:0] q_d1[$], q_d0[$];
    logic        q_o1[$], q_o0[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    coef_mult_pipe #(.DATA_W(25), .OUT_W(25), .SAT(1)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .coef_sel(coef_sel), .coef_neg(coef_neg), .acc_mode(acc_mode), .in_last(in_last),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_ovf(out_ovf1)
    );

    coef_mult_pipe #(.DATA_W(25), .OUT_W(25), .SAT(0)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .coef_sel(coef_sel), .coef_neg(coef_neg), .acc_mode(acc_mode), .in_last(in_last),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_ovf(out_ovf0)
    );

    // Record every completed output transfer of both instances
    always @(negedge clk) begin
        if (!rst && out_ready) begin
            if (out_valid1) begin q_d1.push_back(out_data1); q_o1.push_back(out_ovf1); end
            if (out_valid0) begin q_d0.push_back(out_data0); q_o0.push_back(out_ovf0); end
        end
    end

    // Present one beat and hold it until accepted; returns the cycle count of the accepting edge.
    task automatic send(input logic [24:0] d, input logic [3:0] sel, input logic neg,
                        input logic acc, input logic last, output int acc_cyc);
        logic ok;
        ok = 1'b0;
        acc_cyc = -1;
        in_data = d; coef_sel = sel; coef_neg = neg; acc_mode = acc; in_last = last;
        in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (ok) begin
            @(posedge clk); #1;
            acc_cyc = cyc;
        end else begin
            n_vec++; n_err++;
            $display("FAIL send_accept: in_ready never seen (timeout), expected a beat acceptance");
        end
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for the next output of both instances and pop them.
    task automatic get_out(output logic [24:0] d1, output logic o1, output logic [24:0] d0, output logic o0);
        d1 = '0; o1 = 1'b0; d0 = '0; o0 = 1'b0;
        for (int i = 0; i < 100 && (q_d1.size() == 0 || q_d0.size() == 0); i++) begin
            @(posedge clk); #1;
        end
        if (q_d1.size() == 0 || q_d0.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL get_out: no result observed (timeout), expected one result");
        end else begin
            d1 = q_d1.pop_front(); o1 = q_o1.pop_front();
            d0 = q_d0.pop_front(); o0 = q_o0.pop_front();
        end
    endtask

    task automatic test_reset;
        in_valid = 1'b1;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({in_ready1, out_valid1, out_data1, out_ovf1} !== 28'd0) begin
            n_err++;
            $display("FAIL reset_outputs_pre_edge: got rdy=%b vld=%b data=%0d ovf=%b, expected all 0",
                     in_ready1, out_valid1, out_data1, out_ovf1);
        end
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({in_ready1, out_valid1, out_data1, out_ovf1, in_ready0, out_valid0} !== 30'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b data=%0d ovf=%b, expected all 0",
                     in_ready1, out_valid1, out_data1, out_ovf1);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_vec++;
        if (in_ready1 !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_reset: got in_ready=%b, expected 1", in_ready1);
        end
    endtask

    task automatic test_basic;
        int c;
        logic [24:0] d1, d0;
        logic o1, o0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(25'd100, 4'd0, 1'b0, 1'b0, 1'b0, c);
        n_vec++;
        if (out_valid1 !== 1'b0) begin
            n_err++;
            $display("FAIL latency_early: out_valid=%b one cycle after accept, expected 0", out_valid1);
        end
        @(posedge clk); #1;
        n_vec++;
        if (out_valid1 !== 1'b1 || out_data1 !== 25'd3900 || out_ovf1 !== 1'b0) begin
            n_err++;
            $display("FAIL latency_2cyc: got vld=%b data=%0d ovf=%b, expected vld=1 data=3900 ovf=0",
                     out_valid1, $signed(out_data1), out_ovf1);
        end
        get_out(d1, o1, d0, o0);
        n_vec++;
        if (d1 !== 25'd3900 || o1 !== 1'b0 || d0 !== 25'd3900 || o0 !== 1'b0) begin
            n_err++;
            $display("FAIL basic_100x39: got %0d/%b (wrap %0d/%b), expected 3900/0",
                     $signed(d1), o1, $signed(d0), o0);
        end
    endtask

    task automatic test_neg_zero;
        int c;
        logic [24:0] d1, d0;
        logic o1, o0;
        send(25'(-5), 4'd3, 1'b1, 1'b0, 1'b0, c);
        get_out(d1, o1, d0, o0);
        n_vec++;
        if (d1 !== 25'd150 || o1 !== 1'b0 || d0 !== 25'd150) begin
            n_err++;
            $display("FAIL neg_m5x30: got %0d/%b, expected 150/0", $signed(d1), o1);
        end
        send(25'd7, 4'd13, 1'b0, 1'b0, 1'b0, c);
        get_out(d1, o1, d0, o0);
        n_vec++;
        if (d1 !== 25'd0 || o1 !== 1'b0 || d0 !== 25'd0) begin
            n_err++;
            $display("FAIL zero_coef_sel13: got %0d/%b, expected 0/0", $signed(d1), o1);
        end
    endtask

    task automatic test_saturation;
        int c;
        logic [24:0] d1, d0;
        logic o1, o0;
        send(25'd16777215, 4'd0, 1'b0, 1'b0, 1'b0, c);
        get_out(d1, o1, d0, o0);
        n_vec++;
        if (d1 !== 25'd16777215 || o1 !== 1'b1) begin
            n_err++;
            $display("FAIL sat_pos: got %0d/%b, expected 16777215/1", $signed(d1), o1);
        end
        n_vec++;
        if (d0 !== 25'd16777177 || o0 !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_pos: got %0d/%b, expected 16777177/1", $signed(d0), o0);
        end
        send(25'(-16777216), 4'd0, 1'b0, 1'b0, 1'b0, c);
        get_out(d1, o1, d0, o0);
        n_vec++;
        if (d1 !== 25'(-16777216) || o1 !== 1'b1 || d0 !== 25'(-16777216) || o0 !== 1'b1) begin
            n_err++;
            $display("FAIL sat_wrap_neg: got %0d/%b (wrap %0d/%b), expected -16777216/1 both",
                     $signed(d1), o1, $signed(d0), o0);
        end
        send(25'd1, 4'd11, 1'b0, 1'b0, 1'b0, c);
        get_out(d1, o1, d0, o0);
        n_vec++;
        if (d1 !== 25'd1 || o1 !== 1'b0 || d0 !== 25'd1 || o0 !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_cleared_next: got %0d/%b, expected 1/0", $signed(d1), o1);
        end
    endtask

    task automatic test_accumulate;
        int c;
        logic [24:0] d1, d0;
        logic o1, o0;
        for (int i = 1; i <= 7; i++)
            send(25'(i), 4'd8, 1'b0, 1'b1, 1'b0, c);
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (q_d1.size() != 0 || out_valid1 !== 1'b0) begin
            n_err++;
            $display("FAIL acc_no_early_out: got %0d results, expected 0", q_d1.size());
        end
        send(25'd8, 4'd8, 1'b0, 1'b1, 1'b1, c);
        get_out(d1, o1, d0, o0);
        n_vec++;
        if (d1 !== 25'd288 || o1 !== 1'b0 || d0 !== 25'd288) begin
            n_err++;
            $display("FAIL acc_sum_288: got %0d/%b, expected 288/0", $signed(d1), o1);
        end
        repeat (4) @(posedge clk);
        #1;
        n_vec++;
        if (q_d1.size() != 0) begin
            n_err++;
            $display("FAIL acc_single_out: got %0d extra results, expected 0", q_d1.size());
        end
    endtask

    task automatic test_back_to_back;
        int c0, c1, c2, c3;
        logic [24:0] d1, d0;
        logic o1, o0;
        logic [24:0] exp_d[4];
        exp_d[0] = 25'(-1); exp_d[1] = 25'd16000; exp_d[2] = 25'd18; exp_d[3] = 25'd70;
        send(25'(-1),   4'd11, 1'b0, 1'b0, 1'b0, c0);
        send(25'd1000,  4'd5,  1'b0, 1'b0, 1'b0, c1);
        send(25'(-3),   4'd9,  1'b1, 1'b0, 1'b0, c2);
        send(25'd5,     4'd7,  1'b0, 1'b0, 1'b0, c3);
        n_vec++;
        if (c3 - c0 != 3) begin
            n_err++;
            $display("FAIL b2b_throughput: 4 beats took %0d cycles, expected 3", c3 - c0);
        end
        for (int i = 0; i < 4; i++) begin
            get_out(d1, o1, d0, o0);
            n_vec++;
            if (d1 !== exp_d[i] || d0 !== exp_d[i] || o1 !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_result_%0d: got %0d/%b, expected %0d/0", i, $signed(d1), o1, $signed(exp_d[i]));
            end
        end
    endtask

    task automatic test_backpressure;
        int c;
        logic [24:0] d1, d0;
        logic o1, o0;
        logic [24:0] exp_d[4];
        exp_d[0] = 25'd39; exp_d[1] = 25'd72; exp_d[2] = 25'd105; exp_d[3] = 25'(-76);
        out_ready = 1'b0;
        send(25'd1, 4'd0, 1'b0, 1'b0, 1'b0, c);
        send(25'd2, 4'd1, 1'b0, 1'b0, 1'b0, c);
        n_vec++;
        if (in_ready1 !== 1'b0 || out_valid1 !== 1'b1 || out_data1 !== 25'd39) begin
            n_err++;
            $display("FAIL bp_full: got rdy=%b vld=%b data=%0d, expected rdy=0 vld=1 data=39",
                     in_ready1, out_valid1, $signed(out_data1));
        end
        repeat (4) @(posedge clk);
        #1;
        n_vec++;
        if (in_ready1 !== 1'b0 || out_valid1 !== 1'b1 || out_data1 !== 25'd39 || out_ovf1 !== 1'b0 || q_d1.size() != 0) begin
            n_err++;
            $display("FAIL bp_hold: got rdy=%b vld=%b data=%0d ovf=%b, expected 0/1/39/0 held",
                     in_ready1, out_valid1, $signed(out_data1), out_ovf1);
        end
        out_ready = 1'b1;
        send(25'd3,    4'd2, 1'b0, 1'b0, 1'b0, c);
        send(25'(-4),  4'd4, 1'b0, 1'b0, 1'b0, c);
        for (int i = 0; i < 4; i++) begin
            get_out(d1, o1, d0, o0);
            n_vec++;
            if (d1 !== exp_d[i] || d0 !== exp_d[i]) begin
                n_err++;
                $display("FAIL bp_order_%0d: got %0d, expected %0d", i, $signed(d1), $signed(exp_d[i]));
            end
        end
    endtask

    task automatic test_reset_mid_group;
        int c;
        logic [24:0] d1, d0;
        logic o1, o0;
        for (int i = 0; i < 3; i++)
            send(25'd10, 4'd6, 1'b0, 1'b1, 1'b0, c);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_vec++;
        if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_ready: got rdy=%b vld=%b, expected 1/0", in_ready1, out_valid1);
        end
        send(25'd2, 4'd10, 1'b0, 1'b1, 1'b0, c);
        send(25'd1, 4'd11, 1'b0, 1'b1, 1'b1, c);
        get_out(d1, o1, d0, o0);
        n_vec++;
        if (d1 !== 25'd5 || o1 !== 1'b0 || d0 !== 25'd5) begin
            n_err++;
            $display("FAIL midreset_discard: got %0d/%b, expected 5/0", $signed(d1), o1);
        end
        repeat (4) @(posedge clk);
        #1;
        n_vec++;
        if (q_d1.size() != 0 || q_d0.size() != 0) begin
            n_err++;
            $display("FAIL no_stray_results: got %0d leftover, expected 0", q_d1.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_neg_zero();
        test_saturation();
        test_accumulate();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_group();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
